// File: rtl/sys_reg_file.sv
// ---------------------------------------------------------------------------
// sys_reg_file
//
// Purpose:
//   Configuration / operand register file sitting downstream of the system
//   controller. It accepts write and read commands and returns read data one
//   cycle later with a single-cycle valid strobe. The four reserved entries
//   are exported continuously:
//     entry 0 : ALU operand A
//     entry 1 : ALU operand B
//     entry 2 : UART config (bit0 parity enable, bit1 parity type,
//               bits[7:2] prescale)
//     entry 3 : clock-divider ratio
//
// Ports:
//   i_Ref_clk   in   1          reference clock, rising-edge active
//   i_rst       in   1          asynchronous reset, active-high
//   i_wr_en     in   1          write command
//   i_rd_en     in   1          read command (dropped if i_wr_en also high)
//   i_adder     in   WIDTH_REG  register address
//   i_Wr_D_REG  in   WIDTH_REG  write data
//   o_Rd_D_REG  out  WIDTH_REG  registered read data (holds between reads)
//   o_Vid_Rd    out  1          read-data valid, one cycle per accepted read
//   o_REG0..3   out  WIDTH_REG  direct outputs of entries 0..3
//   o_addr_err  out  1          only with REG_ADDR_CHECK_EN: out-of-range
//                               command flag, aligned with the response cycle
//
// Build option:
//   REG_ADDR_CHECK_EN  When defined, addresses >= DEPTH are rejected: writes
//                      are discarded, reads return 0 with o_Vid_Rd=1, and
//                      o_addr_err pulses. When undefined, only the low ADDR_W
//                      address bits are decoded, so addresses wrap.
// ---------------------------------------------------------------------------
module sys_reg_file #(
    parameter int                   WIDTH_REG     = 8,
    parameter int                   DEPTH         = 16,
    parameter int                   ADDR_W        = 4,
    parameter logic [WIDTH_REG-1:0] UART_CFG_RST  = 8'h81,
    parameter logic [WIDTH_REG-1:0] DIV_RATIO_RST = 8'd32
) (
    input  logic                 i_Ref_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_en,
    input  logic                 i_rd_en,
    input  logic [WIDTH_REG-1:0] i_adder,
    input  logic [WIDTH_REG-1:0] i_Wr_D_REG,
    output logic [WIDTH_REG-1:0] o_Rd_D_REG,
    output logic                 o_Vid_Rd,
    output logic [WIDTH_REG-1:0] o_REG0,
    output logic [WIDTH_REG-1:0] o_REG1,
    output logic [WIDTH_REG-1:0] o_REG2,
    output logic [WIDTH_REG-1:0] o_REG3
`ifdef REG_ADDR_CHECK_EN
    ,
    output logic                 o_addr_err
`endif
);

    // Register storage
    logic [WIDTH_REG-1:0] regs [DEPTH];

    // Address decode
    logic [ADDR_W-1:0]    idx;
    logic [WIDTH_REG-1:0] addr_hi;
    logic                 addr_ok;

    // Command qualification
    logic                 write_hit;
    logic                 read_hit;

    assign idx     = i_adder[ADDR_W-1:0];
    assign addr_hi = i_adder >> ADDR_W;

`ifdef REG_ADDR_CHECK_EN
    // Any set bit above the decoded index means i_adder >= DEPTH.
    assign addr_ok = (addr_hi == '0);
`else
    // Upper address bits are deliberately ignored so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_hi;
    assign addr_ok        = 1'b1;
`endif

    // A write wins over a simultaneous read; the read is simply dropped.
    assign write_hit = i_wr_en && addr_ok;
    assign read_hit  = i_rd_en && !i_wr_en;

    // Storage: the two reserved config entries come out of reset with their
    // functional defaults so the UART and divider work before any write.
    always_ff @(posedge i_Ref_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == 2)
                    regs[i] <= UART_CFG_RST;
                else if (i == 3)
                    regs[i] <= DIV_RATIO_RST;
                else
                    regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[idx] <= i_Wr_D_REG;
        end
    end

    // Read response: data holds between reads, valid is a one-cycle strobe.
    // No forwarding is needed: a same-edge write+read never reaches here.
    always_ff @(posedge i_Ref_clk or posedge i_rst) begin
        if (i_rst) begin
            o_Rd_D_REG <= '0;
            o_Vid_Rd   <= 1'b0;
        end else begin
            o_Vid_Rd <= read_hit;
            if (read_hit)
                o_Rd_D_REG <= addr_ok ? regs[idx] : '0;
        end
    end

`ifdef REG_ADDR_CHECK_EN
    // Flag any out-of-range command, write or read, in its response cycle.
    always_ff @(posedge i_Ref_clk or posedge i_rst) begin
        if (i_rst)
            o_addr_err <= 1'b0;
        else
            o_addr_err <= (i_wr_en || i_rd_en) && !addr_ok;
    end
`endif

    // Reserved entries are exported straight from the flops.
    assign o_REG0 = regs[0];
    assign o_REG1 = regs[1];
    assign o_REG2 = regs[2];
    assign o_REG3 = regs[3];

endmodule

// File: tb/tb_sys_reg_file.sv
// ---------------------------------------------------------------------------
// tb_sys_reg_file
//
// Self-checking bench for sys_reg_file: a directed vector table, a hand
// sequence for the mid-cycle asynchronous reset, and a randomized phase
// compared against an array-based reference model.
// Define REG_ADDR_CHECK_EN for both bench and RTL to test the checked build.
// ---------------------------------------------------------------------------
module tb_sys_reg_file;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic         i_Ref_clk = 1'b0;
    logic         i_rst;
    logic         i_wr_en;
    logic         i_rd_en;
    logic [W-1:0] i_adder;
    logic [W-1:0] i_Wr_D_REG;
    logic [W-1:0] o_Rd_D_REG;
    logic         o_Vid_Rd;
    logic [W-1:0] o_REG0, o_REG1, o_REG2, o_REG3;
`ifdef REG_ADDR_CHECK_EN
    logic         o_addr_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] m_mem [DEPTH];
    logic [W-1:0] m_rd;
    logic         m_vld;
    logic         m_err;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [W-1:0] addr;
        logic [W-1:0] data;
        logic [W-1:0] exp_rd;
        bit           exp_vld;
        bit           exp_err;
        logic [W-1:0] exp_r0;
        logic [W-1:0] exp_r1;
        logic [W-1:0] exp_r2;
        logic [W-1:0] exp_r3;
    } vec_t;

    vec_t vecs [$];

    sys_reg_file dut (
        .i_Ref_clk  (i_Ref_clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_wr_en),
        .i_rd_en    (i_rd_en),
        .i_adder    (i_adder),
        .i_Wr_D_REG (i_Wr_D_REG),
        .o_Rd_D_REG (o_Rd_D_REG),
        .o_Vid_Rd   (o_Vid_Rd),
        .o_REG0     (o_REG0),
        .o_REG1     (o_REG1),
        .o_REG2     (o_REG2),
        .o_REG3     (o_REG3)
`ifdef REG_ADDR_CHECK_EN
        ,
        .o_addr_err (o_addr_err)
`endif
    );

    always #5 i_Ref_clk = ~i_Ref_clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_mem[2] = 8'h81;
        m_mem[3] = 8'd32;
        m_rd     = '0;
        m_vld    = 1'b0;
        m_err    = 1'b0;
    endtask

    // Behavioural rule set: write wins, reads return current contents,
    // out-of-range (checked build only) writes vanish and reads give 0.
    task automatic modelStep(input bit wr, input bit rd, input logic [W-1:0] addr,
                             input logic [W-1:0] data);
        bit in_range;
        int idx;
`ifdef REG_ADDR_CHECK_EN
        in_range = (int'(addr) < DEPTH);
`else
        in_range = 1'b1;
`endif
        idx   = int'(addr) % DEPTH;
        m_err = (wr || rd) && !in_range;
        if (wr && in_range) m_mem[idx] = data;
        m_vld = rd && !wr;
        if (m_vld) m_rd = in_range ? m_mem[idx] : '0;
    endtask

    // Drive one command for one clock, then let the outputs settle.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [W-1:0] addr,
                                 input logic [W-1:0] data);
        @(negedge i_Ref_clk);
        i_wr_en    = wr;
        i_rd_en    = rd;
        i_adder    = addr;
        i_Wr_D_REG = data;
        @(posedge i_Ref_clk);
        #1;
        modelStep(wr, rd, addr, data);
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, " vld"},  32'(o_Vid_Rd),   32'(m_vld));
        checkOutput({tag, " rd"},   32'(o_Rd_D_REG), 32'(m_rd));
        checkOutput({tag, " reg0"}, 32'(o_REG0),     32'(m_mem[0]));
        checkOutput({tag, " reg1"}, 32'(o_REG1),     32'(m_mem[1]));
        checkOutput({tag, " reg2"}, 32'(o_REG2),     32'(m_mem[2]));
        checkOutput({tag, " reg3"}, 32'(o_REG3),     32'(m_mem[3]));
`ifdef REG_ADDR_CHECK_EN
        checkOutput({tag, " err"},  32'(o_addr_err), 32'(m_err));
`endif
    endtask

    task automatic addVec(input bit wr, input bit rd, input logic [W-1:0] addr,
                          input logic [W-1:0] data, input logic [W-1:0] erd,
                          input bit evld, input bit eerr, input logic [W-1:0] r0,
                          input logic [W-1:0] r1, input logic [W-1:0] r2,
                          input logic [W-1:0] r3);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.data = data;
        v.exp_rd = erd; v.exp_vld = evld; v.exp_err = eerr;
        v.exp_r0 = r0; v.exp_r1 = r1; v.exp_r2 = r2; v.exp_r3 = r3;
        vecs.push_back(v);
    endtask

    initial begin
        // Directed table: wr rd addr data | rd vld err reg0 reg1 reg2 reg3
        addVec(1, 0, 8'h04, 8'hD9, 8'h00, 0, 0, 8'h00, 8'h00, 8'h81, 8'h20);
        addVec(0, 1, 8'h04, 8'h00, 8'hD9, 1, 0, 8'h00, 8'h00, 8'h81, 8'h20);
        addVec(0, 0, 8'h04, 8'h00, 8'hD9, 0, 0, 8'h00, 8'h00, 8'h81, 8'h20);
        addVec(1, 0, 8'h00, 8'd12, 8'hD9, 0, 0, 8'd12,  8'h00, 8'h81, 8'h20);
        addVec(1, 0, 8'h01, 8'd10, 8'hD9, 0, 0, 8'd12,  8'd10, 8'h81, 8'h20);
        addVec(0, 1, 8'h02, 8'h00, 8'h81, 1, 0, 8'd12,  8'd10, 8'h81, 8'h20);
        addVec(0, 1, 8'h03, 8'h00, 8'h20, 1, 0, 8'd12,  8'd10, 8'h81, 8'h20);
        addVec(1, 1, 8'h05, 8'hCC, 8'h20, 0, 0, 8'd12,  8'd10, 8'h81, 8'h20);
        addVec(0, 1, 8'h05, 8'h00, 8'hCC, 1, 0, 8'd12,  8'd10, 8'h81, 8'h20);
        addVec(1, 0, 8'h06, 8'h77, 8'hCC, 0, 0, 8'd12,  8'd10, 8'h81, 8'h20);
        addVec(0, 1, 8'h06, 8'h00, 8'h77, 1, 0, 8'd12,  8'd10, 8'h81, 8'h20);
`ifdef REG_ADDR_CHECK_EN
        addVec(1, 0, 8'h13, 8'hAA, 8'h77, 0, 1, 8'd12,  8'd10, 8'h81, 8'h20);
        addVec(0, 1, 8'h13, 8'h00, 8'h00, 1, 1, 8'd12,  8'd10, 8'h81, 8'h20);
`else
        addVec(1, 0, 8'h13, 8'hAA, 8'h77, 0, 0, 8'd12,  8'd10, 8'h81, 8'hAA);
        addVec(0, 1, 8'h13, 8'h00, 8'hAA, 1, 0, 8'd12,  8'd10, 8'h81, 8'hAA);
`endif
        addVec(0, 0, 8'h00, 8'h00, 8'hAA, 0, 0, 8'd12,  8'd10, 8'h81, 8'h20);
        addVec(0, 1, 8'h00, 8'h00, 8'd12, 1, 0, 8'd12,  8'd10, 8'h81, 8'h20);
`ifndef REG_ADDR_CHECK_EN
        // Fix up the tail for the wrap build, where entry 3 now holds 0xAA
        // and the held read data after the idle cycle is 0xAA.
        vecs[13].exp_r3 = 8'hAA;
        vecs[14].exp_r3 = 8'hAA;
`else
        vecs[13].exp_rd = 8'h00;
`endif

        i_rst = 1'b1; i_wr_en = 1'b0; i_rd_en = 1'b0;
        i_adder = '0; i_Wr_D_REG = '0;
        modelReset();
        #12;
        checkOutput("reset reg0", 32'(o_REG0), 32'h00);
        checkOutput("reset reg1", 32'(o_REG1), 32'h00);
        checkOutput("reset reg2", 32'(o_REG2), 32'h81);
        checkOutput("reset reg3", 32'(o_REG3), 32'd32);
        checkOutput("reset vld",  32'(o_Vid_Rd), 32'h0);
        checkOutput("reset rd",   32'(o_Rd_D_REG), 32'h0);
        @(negedge i_Ref_clk);
        i_rst = 1'b0;

        $display("[TB] directed vectors");
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].data);
            checkOutput($sformatf("vec%0d vld", k),  32'(o_Vid_Rd),   32'(vecs[k].exp_vld));
            checkOutput($sformatf("vec%0d rd", k),   32'(o_Rd_D_REG), 32'(vecs[k].exp_rd));
            checkOutput($sformatf("vec%0d reg0", k), 32'(o_REG0),     32'(vecs[k].exp_r0));
            checkOutput($sformatf("vec%0d reg1", k), 32'(o_REG1),     32'(vecs[k].exp_r1));
            checkOutput($sformatf("vec%0d reg2", k), 32'(o_REG2),     32'(vecs[k].exp_r2));
            checkOutput($sformatf("vec%0d reg3", k), 32'(o_REG3),     32'(vecs[k].exp_r3));
`ifdef REG_ADDR_CHECK_EN
            checkOutput($sformatf("vec%0d err", k),  32'(o_addr_err), 32'(vecs[k].exp_err));
`endif
        end

        // Mid-cycle reset with a valid strobe up and a read in flight.
        $display("[TB] mid-cycle reset");
        applyStimulus(1, 0, 8'h01, 8'h5A);
        applyStimulus(0, 1, 8'h01, 8'h00);
        checkOutput("pre-rst vld", 32'(o_Vid_Rd),   32'h1);
        checkOutput("pre-rst rd",  32'(o_Rd_D_REG), 32'h5A);
        @(negedge i_Ref_clk);
        i_rd_en = 1'b1; i_adder = 8'h01;
        #2 i_rst = 1'b1;
        #1;
        checkOutput("async reg0", 32'(o_REG0),     32'h00);
        checkOutput("async reg1", 32'(o_REG1),     32'h00);
        checkOutput("async reg2", 32'(o_REG2),     32'h81);
        checkOutput("async reg3", 32'(o_REG3),     32'd32);
        checkOutput("async vld",  32'(o_Vid_Rd),   32'h0);
        checkOutput("async rd",   32'(o_Rd_D_REG), 32'h0);
        @(posedge i_Ref_clk);
        #1;
        checkOutput("inflight vld", 32'(o_Vid_Rd), 32'h0);
        @(negedge i_Ref_clk);
        i_rst = 1'b0; i_rd_en = 1'b0;
        modelReset();

        $display("[TB] randomized phase");
        for (int n = 0; n < 400; n++) begin
            bit           wr, rd;
            logic [W-1:0] addr, data;
            wr   = ($urandom_range(0, 99) < 40);
            rd   = ($urandom_range(0, 99) < 50);
            addr = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                               : W'($urandom_range(0, 19));
            data = W'($urandom);
            applyStimulus(wr, rd, addr, data);
            checkAgainstModel($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_reg_file.md
Name: sys_reg_file

Overview:
- Configuration/operand register file that sits directly downstream of the system controller.
- Accepts write and read commands (address, data, enables) and returns read data with a one-cycle valid strobe.
- Continuously exports the four reserved registers: ALU operand A, ALU operand B, UART config and clock-divider ratio.
- Also feeds the ALU, UART and clock divider; the controller forwards read data to the TX FIFO.

Parameters:
- WIDTH_REG, 8, data width of every register and width of the incoming address bus
- DEPTH, 16, number of registers (power of two, 4..2^WIDTH_REG)
- ADDR_W, 4, log2(DEPTH); index bits actually decoded from i_adder
- UART_CFG_RST, 8'h81, REG2 reset value: bit0 parity enable=1, bit1 parity type=0 (even), bits[7:2] prescale=32
- DIV_RATIO_RST, 8'd32, REG3 reset value (clock-divider ratio)

Ports:
- i_Ref_clk  input  1  reference clock; all state updates on its rising edge
- i_rst  input  1  asynchronous reset, active-high
- i_wr_en  input  1  write command, sampled each rising edge
- i_rd_en  input  1  read command, sampled each rising edge
- i_adder  input  WIDTH_REG  register address
- i_Wr_D_REG  input  WIDTH_REG  write data
- o_Rd_D_REG  output  WIDTH_REG  registered read data
- o_Vid_Rd  output  1  read-data valid, one cycle per accepted read
- o_REG0  output  WIDTH_REG  ALU operand A (entry 0)
- o_REG1  output  WIDTH_REG  ALU operand B (entry 1)
- o_REG2  output  WIDTH_REG  UART config (entry 2)
- o_REG3  output  WIDTH_REG  divider ratio (entry 3)

Behaviour:
- Reset (async, while i_rst=1):
  - All entries cleared to 0, except entry 2=UART_CFG_RST and entry 3=DIV_RATIO_RST.
  - o_Rd_D_REG=0, o_Vid_Rd=0.
  - Takes effect immediately, mid-command included; an in-flight read produces no valid strobe.
- Index is i_adder[ADDR_W-1:0]. Upper bits are ignored (wrap: 0x13 -> entry 3) unless REG_ADDR_CHECK_EN is defined.
- Write (i_wr_en=1, i_rd_en=0):
  - Entry updated at the rising edge.
  - o_REG0..3 reflect the new value from that edge (zero added latency).
- Read (i_rd_en=1, i_wr_en=0):
  - At the rising edge, o_Rd_D_REG <= entry[index] and o_Vid_Rd <= 1; data appears one cycle after the command.
  - o_Vid_Rd is high only in the cycle after each accepted read; back-to-back reads keep it high every cycle with new data each cycle.
- Both enables high: write executes, read is dropped, o_Vid_Rd=0 next cycle.
- Neither enable high: o_Vid_Rd=0, o_Rd_D_REG holds its last value.
- Read of an entry written in the previous cycle returns the new value.
- No forwarding exists within the same edge; a same-edge write and read resolves by the both-enables rule above.
- o_REG0..o_REG3 are direct register outputs, glitch-free, and never gated by the enables.

Optional Feature:
- Macro REG_ADDR_CHECK_EN.
- Defined:
  - Adds output o_addr_err (1 bit, reset 0).
  - A command with i_adder >= DEPTH is out of range:
    - Write is discarded (no entry changes).
    - Read returns o_Rd_D_REG=0 with o_Vid_Rd=1.
  - o_addr_err pulses 1 cycle, aligned with the response cycle of that command.
- Undefined:
  - Port absent; upper address bits ignored (wrap-around behaviour above).

Test Plan:
- Reset: pulse i_rst high mid-cycle -> o_REG0=0, o_REG1=0, o_REG2=8'h81, o_REG3=8'd32, o_Vid_Rd=0, all asynchronously.
- Write/read: write 8'hD9 to addr 4, then read addr 4 -> next cycle o_Rd_D_REG=8'hD9, o_Vid_Rd=1 for exactly one cycle.
- Operand export: write 8'd12 to addr 0 and 8'd10 to addr 1 -> o_REG0=12 and o_REG1=10 from the write edges.
- Back-to-back reads: reads of addr 2 then addr 3 on consecutive cycles -> o_Rd_D_REG=8'h81 then 8'd32, o_Vid_Rd held high 2 cycles.
- Collision: i_wr_en=i_rd_en=1, addr 5, data 8'hCC -> entry 5=8'hCC, o_Vid_Rd=0, o_Rd_D_REG unchanged.
- Address range: write 8'hAA to addr 8'h13.
  - Macro off: o_REG3=8'hAA.
  - Macro on: o_REG3 stays 32 and o_addr_err pulses 1 cycle; a read of 8'h13 returns 0 with o_Vid_Rd=1.
